// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: turns button presses and per-frame hit/miss
// pulses from the graphics block into the game state, BCD score, lives,
// bricks-remaining count, a brick-field clear strobe and a hold timer.
module breakout_game_ctrl #(
  parameter int unsigned LIVES       = 3,
  parameter int unsigned NUM_BRICKS  = 48,
  parameter int unsigned TIMER_TICKS = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  btn_i,
  input  logic        refr_tick_i,
  input  logic        hit_i,
  input  logic        miss_i,
  output logic        gra_still_o,
  output logic        clear_bricks_o,
  output logic [2:0]  state_o,
  output logic [1:0]  lives_o,
  output logic [15:0] score_o,
  output logic [5:0]  bricks_left_o,
  output logic        timer_busy_o
);

  typedef enum logic [2:0] {
    S_NEWGAME = 3'd0,
    S_PLAY    = 3'd1,
    S_NEWBALL = 3'd2,
    S_OVER    = 3'd3,
    S_WIN     = 3'd4
  } state_t;

  localparam logic [1:0] LIVES_INIT  = 2'(LIVES);
  localparam logic [5:0] BRICKS_INIT = 6'(NUM_BRICKS);
  localparam logic [6:0] TIMER_INIT  = 7'(TIMER_TICKS);

  // Saturating 4-digit BCD increment: 9999 stays 9999.
  function automatic logic [15:0] bcd_inc_sat(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (v[i*4 +: 4] >= 4'd9) begin
            r[i*4 +: 4] = 4'd0;
            carry       = 1'b1;
          end else begin
            r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4];
        end
      end
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t      state_q;
  logic [1:0]  lives_q;
  logic [15:0] score_q;
  logic [5:0]  bricks_q;
  logic [6:0]  timer_q;
  logic        clear_q;
  logic        btn_prev_q;

  logic        btn_any_s;
  logic        press_s;
  logic        hit_ok_s;
  logic        win_s;
  logic        load_s;
  logic [15:0] score_d;

  // Press detection, hit qualification and timer-load decode from current state.
  always_comb begin
    btn_any_s = |btn_i;
    press_s   = btn_any_s & ~btn_prev_q;
    // A hit with an empty field cannot happen legally; it is dropped.
    hit_ok_s  = (state_q == S_PLAY) && hit_i && (bricks_q != 6'd0);
    win_s     = hit_ok_s && (bricks_q == 6'd1);
    load_s    = win_s || ((state_q == S_PLAY) && miss_i);
    score_d   = bcd_inc_sat(score_q);
  end

  // Game FSM together with its counters, hold timer and clear strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_NEWGAME;
      lives_q    <= LIVES_INIT;
      score_q    <= 16'h0000;
      bricks_q   <= BRICKS_INIT;
      timer_q    <= 7'd0;
      clear_q    <= 1'b0;
      btn_prev_q <= 1'b0;
    end else begin
      btn_prev_q <= btn_any_s;
      clear_q    <= 1'b0;

      // Load has priority over the refresh-tick countdown.
      if (load_s) begin
        timer_q <= TIMER_INIT;
      end else if (refr_tick_i && (timer_q != 7'd0)) begin
        timer_q <= timer_q - 7'd1;
      end else begin
        timer_q <= timer_q;
      end

      case (state_q)
        S_NEWGAME: begin
          if (press_s) begin
            score_q  <= 16'h0000;
            lives_q  <= LIVES_INIT;
            bricks_q <= BRICKS_INIT;
            clear_q  <= 1'b1;
            state_q  <= S_PLAY;
          end else begin
            state_q <= S_NEWGAME;
          end
        end
        S_PLAY: begin
          if (hit_ok_s) begin
            score_q  <= score_d;
            bricks_q <= bricks_q - 6'd1;
          end else begin
            bricks_q <= bricks_q;
          end
          // Emptying the field wins even if the ball is lost in the same cycle.
          if (win_s) begin
            state_q <= S_WIN;
          end else if (miss_i) begin
            if (lives_q <= 2'd1) begin
              lives_q <= 2'd0;
              state_q <= S_OVER;
            end else begin
              lives_q <= lives_q - 2'd1;
              state_q <= S_NEWBALL;
            end
          end else begin
            state_q <= S_PLAY;
          end
        end
        S_NEWBALL: begin
          // Presses during the hold are simply dropped, never queued.
          if ((timer_q == 7'd0) && press_s) begin
            state_q <= S_PLAY;
          end else begin
            state_q <= S_NEWBALL;
          end
        end
        S_OVER, S_WIN: begin
          if (timer_q == 7'd0) begin
            state_q <= S_NEWGAME;
          end else begin
            state_q <= state_q;
          end
        end
        default: begin
          state_q <= S_NEWGAME;
        end
      endcase
    end
  end

  assign gra_still_o    = (state_q != S_PLAY);
  assign clear_bricks_o = clear_q;
  assign state_o        = state_q;
  assign lives_o        = lives_q;
  assign score_o        = score_q;
  assign bricks_left_o  = bricks_q;
  assign timer_busy_o   = (timer_q != 7'd0);

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Scoreboard bench for breakout_game_ctrl: directed game scenarios plus a
// randomized phase, each cycle checked against an integer game model.
module tb_breakout_game_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  btn = 5'd0;
  logic        refr = 1'b0;
  logic        hit = 1'b0;
  logic        miss = 1'b0;
  logic        gra_still_o, clear_bricks_o, timer_busy_o;
  logic [2:0]  state_o;
  logic [1:0]  lives_o;
  logic [15:0] score_o;
  logic [5:0]  bricks_left_o;
  logic [15:0] pre_v;

  always #5 clk = ~clk;

  breakout_game_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .btn_i         (btn),
    .refr_tick_i   (refr),
    .hit_i         (hit),
    .miss_i        (miss),
    .gra_still_o   (gra_still_o),
    .clear_bricks_o(clear_bricks_o),
    .state_o       (state_o),
    .lives_o       (lives_o),
    .score_o       (score_o),
    .bricks_left_o (bricks_left_o),
    .timer_busy_o  (timer_busy_o)
  );

  typedef struct {
    int st;
    int lives;
    int score;
    int bricks;
    int clr;
    int busy;
  } snap_t;

  snap_t exp_q[$];
  snap_t e;
  int total = 0;
  int bad   = 0;

  // Game model: plain integers; states 0=NEWGAME 1=PLAY 2=NEWBALL 3=OVER 4=WIN
  int m_st, m_lives, m_score, m_bricks, m_timer, m_clr, m_bprev;

  function automatic logic [15:0] to_bcd(input int s);
    return 16'(((s / 1000) % 10) * 4096 + ((s / 100) % 10) * 256 + ((s / 10) % 10) * 16 + (s % 10));
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_lives = 3; m_score = 0; m_bricks = 48;
    m_timer = 0; m_clr = 0; m_bprev = 0;
  endtask

  task automatic model_next(input logic [4:0] b, input logic r, input logic h, input logic m);
    int press;
    int t0;
    int load;
    press   = ((b != 5'd0) && (m_bprev == 0)) ? 1 : 0;
    t0      = m_timer;
    load    = 0;
    m_bprev = (b != 5'd0) ? 1 : 0;
    m_clr   = 0;
    case (m_st)
      0: if (press == 1) begin
           m_score = 0; m_lives = 3; m_bricks = 48; m_clr = 1; m_st = 1;
         end
      1: begin
           if (h && m_bricks > 0) begin
             if (m_score < 9999) m_score++;
             m_bricks--;
             if (m_bricks == 0) begin m_st = 4; load = 1; end
           end
           if (m && m_st == 1) begin
             m_lives--;
             m_st = (m_lives == 0) ? 3 : 2;
             load = 1;
           end
         end
      2: if (t0 == 0 && press == 1) m_st = 1;
      3, 4: if (t0 == 0) m_st = 0;
      default: m_st = 0;
    endcase
    if (load == 1) m_timer = 120;
    else if (r && m_timer > 0) m_timer--;
  endtask

  task automatic push_snap();
    snap_t s;
    s.st = m_st; s.lives = m_lives; s.score = int'(to_bcd(m_score));
    s.bricks = m_bricks; s.clr = m_clr; s.busy = (m_timer != 0) ? 1 : 0;
    exp_q.push_back(s);
  endtask

  // Monitor: on every falling edge with an outstanding expectation, compare all outputs.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("state", int'(state_o), e.st);
      chk("lives", int'(lives_o), e.lives);
      chk("score", int'(score_o), e.score);
      chk("bricks_left", int'(bricks_left_o), e.bricks);
      chk("clear_bricks", int'(clear_bricks_o), e.clr);
      chk("timer_busy", int'(timer_busy_o), e.busy);
      chk("gra_still", int'(gra_still_o), (e.st != 1) ? 1 : 0);
    end
  end

  // One clock: record what the DUT should now show, then apply new inputs.
  task automatic step(input logic [4:0] b, input logic r, input logic h, input logic m);
    @(posedge clk); #1;
    push_snap();
    reset = 1'b0; btn = b; refr = r; hit = h; miss = m;
    model_next(b, r, h, m);
  endtask

  task automatic idle();
    step(5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; btn = 5'd0; refr = 1'b0; hit = 1'b0; miss = 1'b0;
    model_reset();
    #1;
    push_snap();
  endtask

  task automatic ticks(input int n, input int press_at);
    for (int j = 0; j < n; j++) step((j == press_at) ? 5'h04 : 5'h00, 1'b1, 1'b0, 1'b0);
  endtask

  // Preload the score register while the game sits idle in PLAY.
  task automatic preload(input int v);
    @(posedge clk); #1;
    pre_v = to_bcd(v);
    force dut.score_q = pre_v;
    #1;
    release dut.score_q;
    m_score = v;
  endtask

  initial begin
    model_reset();
    do_reset();
    chk("rst_state", int'(state_o), 0);
    chk("rst_score", int'(score_o), 0);
    chk("rst_bricks", int'(bricks_left_o), 48);
    chk("rst_lives", int'(lives_o), 3);
    chk("rst_clear", int'(clear_bricks_o), 0);
    idle(); idle();

    // Held button starts exactly one game.
    for (int k = 0; k < 6; k++) step(5'h01, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    idle(); idle();
    chk("start_state", int'(state_o), 1);
    chk("start_still", int'(gra_still_o), 0);

    // Twelve hits with random gaps and button noise.
    for (int k = 0; k < 12; k++) begin
      step(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      if ($urandom_range(0, 1) == 1) step(5'd0, 1'b0, 1'b0, 1'b0);
    end
    idle(); idle();
    chk("score12", int'(score_o), 'h0012);
    chk("bricks36", int'(bricks_left_o), 36);

    // Three misses; press at tick 60 of each hold must be ignored.
    for (int i = 0; i < 3; i++) begin
      step(5'd0, 1'b0, 1'b0, 1'b1);
      idle();
      chk("miss_lives", int'(lives_o), 2 - i);
      chk("miss_state", int'(state_o), (i == 2) ? 3 : 2);
      ticks(125, 60);
      idle();
      if (i < 2) begin
        chk("hold_state", int'(state_o), 2);
        step(5'h01, 1'b0, 1'b0, 1'b0);
        idle(); idle();
        chk("resume_state", int'(state_o), 1);
      end
    end
    chk("over_to_newgame", int'(state_o), 0);
    chk("over_score_held", int'(score_o), 'h0012);

    // Empty the field with hit+miss together: win, lives untouched.
    step(5'h10, 1'b0, 1'b0, 1'b0);
    idle();
    for (int k = 0; k < 47; k++) begin
      step(5'd0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      if ($urandom_range(0, 2) == 0) idle();
    end
    step(5'd0, 1'b0, 1'b1, 1'b1);
    idle();
    chk("win_state", int'(state_o), 4);
    chk("win_lives", int'(lives_o), 3);
    chk("win_bricks", int'(bricks_left_o), 0);
    chk("win_score", int'(score_o), 'h0048);
    ticks(125, -1);
    idle();
    chk("win_to_newgame", int'(state_o), 0);

    // Saturation and BCD carry through preloaded scores.
    step(5'h02, 1'b0, 1'b0, 1'b0);
    idle(); idle();
    preload(9998);
    step(5'd0, 1'b0, 1'b1, 1'b0); idle();
    chk("score9999", int'(score_o), 'h9999);
    step(5'd0, 1'b0, 1'b1, 1'b0); idle();
    chk("score_sat", int'(score_o), 'h9999);
    preload(99);
    step(5'd0, 1'b0, 1'b1, 1'b0); idle();
    chk("score0100", int'(score_o), 'h0100);

    // Randomized play.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 50) == 0));
    end

    // Reset in NEWBALL with the timer part way down.
    do_reset();
    step(5'h08, 1'b0, 1'b0, 1'b0);
    idle();
    for (int k = 0; k < 5; k++) step(5'd0, 1'b0, 1'b1, 1'b0);
    step(5'd0, 1'b0, 1'b0, 1'b1);
    ticks(70, -1);
    idle();
    chk("nb_busy", int'(timer_busy_o), 1);
    chk("nb_score", int'(score_o), 'h0005);
    do_reset();
    chk("mid_rst_state", int'(state_o), 0);
    chk("mid_rst_busy", int'(timer_busy_o), 0);
    chk("mid_rst_score", int'(score_o), 0);
    chk("mid_rst_lives", int'(lives_o), 3);
    chk("mid_rst_bricks", int'(bricks_left_o), 48);
    for (int k = 0; k < 3; k++) step(5'd0, 1'b0, 1'b1, 1'b0);
    idle(); idle();
    chk("ng_hit_score", int'(score_o), 0);
    chk("ng_hit_bricks", int'(bricks_left_o), 48);
    chk("ng_clear", int'(clear_bricks_o), 0);

    @(negedge clk); #1;
    chk("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
